note_snapper: RTL

Upstream stage of the pitch-shift divider. Takes each fundamental-frequency estimate from the pitch detector and snaps it to the nearest equal-tempered note enabled in a 12-bit scale mask. It then presents the snapped target frequency together with the held fundamental, and pulses the divider's start. All frequencies use the divider's fixed-point format: 32-bit word, bit 31 = sign, 20 fractional bits, unsigned magnitude in Hz.

---
 rtl/note_snapper_pkg.sv | 45 ++++
 rtl/note_rom.sv | 25 ++
 rtl/note_snapper.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/note_snapper_pkg.sv
// rtl/note_snapper_pkg.sv - shared constants, state encoding and note table for note_snapper
package note_snapper_pkg;

    localparam int NOTE_COUNT = 72;
    localparam int Q          = 20;
    localparam int N          = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    // 2^(s/12) scaled by 1e16; the table is anchored on A = 440 Hz exactly
    localparam logic [63:0] SEMI_RATIO [12] = '{
        64'd10000000000000000, 64'd10594630943592953, 64'd11224620483093730,
        64'd11892071150027210, 64'd12599210498948732, 64'd13348398541700344,
        64'd14142135623730951, 64'd14983070768766815, 64'd15874010519681994,
        64'd16817928305074290, 64'd17817974362806785, 64'd18877486253633870
    };

    // Entry i is MIDI 24+i; counted from A0 (27.5 Hz = 55 * 2^(Q-1)) so octaves are exact shifts
    function automatic logic [N-1:0] note_freq(input int i);
        logic [127:0] acc;
        int oct;
        int semi;
        oct  = (i + 3) / 12;
        semi = (i + 3) % 12;
        acc  = 128'(55) * 128'(SEMI_RATIO[semi[3:0]]) << (Q - 1 + oct);
        acc  = (acc + 128'd5000000000000000) / 128'd10000000000000000;
        return N'(acc);
    endfunction

    function automatic logic [NOTE_COUNT*N-1:0] build_table();
        logic [NOTE_COUNT*N-1:0] t;
        t = '0;
        for (int i = 0; i < NOTE_COUNT; i++) begin
            t = {note_freq(i), t[NOTE_COUNT*N-1:N]};
        end
        return t;
    endfunction

    localparam logic [NOTE_COUNT*N-1:0] NOTE_TABLE = build_table();

endpackage

// File: rtl/note_rom.sv
// rtl/note_rom.sv - registered equal-tempered note frequency table, one-cycle latency
module note_rom
    import note_snapper_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [6:0]   addr,
    output logic [N-1:0] data
);

    logic [11:0] base;

    assign base = 12'(addr) * 12'(N);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else if (addr < 7'(NOTE_COUNT)) begin
            data <= NOTE_TABLE[base +: N];
        end else begin
            data <= '0;
        end
    end

endmodule

// File: rtl/note_snapper.sv
// rtl/note_snapper.sv - snaps a fundamental estimate to the nearest enabled note and starts the divider
module note_snapper
    import note_snapper_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] freq_in,
    input  logic         fund_valid,
    input  logic [11:0]  scale_mask,
    output logic         busy,
    output logic [N-1:0] freq_fund,
    output logic [N-1:0] freq_desired,
    output logic [6:0]   note_index,
    output logic         div_start,
    output logic         snap_done,
    output logic         unvoiced
);

    localparam logic [6:0] LAST_IDX = 7'(NOTE_COUNT - 1);

    state_t       state, state_next;
    logic [11:0]  mask_q;
    logic         req_unvoiced, req_pass;
    logic [6:0]   scan_idx, ent_idx;
    logic [3:0]   scan_pc, ent_pc;
    logic         ent_vld;
    logic [N-1:0] rom_q;
    logic         best_vld;
    logic [N-2:0] best_dist;
    logic [6:0]   best_idx;
    logic [N-1:0] best_freq;
    logic [N-1:0] dist_full;
    logic         in_unvoiced, capture, scan_step, last_cmp, take;

    note_rom u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  (scan_idx),
        .data  (rom_q)
    );

    assign in_unvoiced = (freq_in == '0) || freq_in[N-1];
    assign scan_step   = (state == ST_SCAN) && (scan_idx <= LAST_IDX);
    assign last_cmp    = ent_vld && (ent_idx == LAST_IDX);
    assign dist_full   = (freq_fund >= rom_q) ? (freq_fund - rom_q) : (rom_q - freq_fund);
    // Strictly-smaller replacement keeps the lower note on a tie
    assign take        = ent_vld && mask_q[ent_pc] && (!best_vld || (dist_full < {1'b0, best_dist}));
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fund_valid) begin
                    capture    = 1'b1;
                    state_next = (in_unvoiced || (scale_mask == '0)) ? ST_DONE : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (last_cmp) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freq_fund    <= '0;
            freq_desired <= '0;
            note_index   <= '0;
            div_start    <= 1'b0;
            snap_done    <= 1'b0;
            unvoiced     <= 1'b0;
            mask_q       <= '0;
            req_unvoiced <= 1'b0;
            req_pass     <= 1'b0;
            scan_idx     <= '0;
            scan_pc      <= '0;
            ent_idx      <= '0;
            ent_pc       <= '0;
            ent_vld      <= 1'b0;
            best_vld     <= 1'b0;
            best_dist    <= '0;
            best_idx     <= '0;
            best_freq    <= '0;
        end else begin
            div_start <= 1'b0;
            snap_done <= 1'b0;
            unvoiced  <= 1'b0;
            if (capture) begin
                freq_fund    <= freq_in;
                mask_q       <= scale_mask;
                req_unvoiced <= in_unvoiced;
                req_pass     <= (scale_mask == '0);
                scan_idx     <= '0;
                scan_pc      <= '0;
                best_vld     <= 1'b0;
            end
            if (scan_step) begin
                scan_idx <= scan_idx + 7'd1;
                scan_pc  <= (scan_pc == 4'd11) ? 4'd0 : scan_pc + 4'd1;
            end
            // Entry tags trail the address by one cycle to line up with the registered ROM word
            ent_vld <= scan_step;
            ent_idx <= scan_idx;
            ent_pc  <= scan_pc;
            if (take) begin
                best_vld  <= 1'b1;
                best_dist <= dist_full[N-2:0];
                best_idx  <= ent_idx;
                best_freq <= rom_q;
            end
            if (state == ST_DONE) begin
                snap_done <= 1'b1;
                if (req_unvoiced) begin
                    freq_desired <= '0;
                    note_index   <= '0;
                    unvoiced     <= 1'b1;
                end else if (req_pass) begin
                    freq_desired <= freq_fund;
                    note_index   <= '0;
                    div_start    <= 1'b1;
                end else begin
                    freq_desired <= best_freq;
                    note_index   <= best_idx;
                    div_start    <= 1'b1;
                end
            end
        end
    end

endmodule
